// File: rtl/wait_state_data_memory_if.sv
// wait_state_data_memory_if: core data port extended with Ready/Stall handshake
interface wait_state_data_memory_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0] Address, WriteData, ReadData;
    logic MemRead, MemWrite, Ready, Stall;
    modport master(output Address, WriteData, MemRead, MemWrite, input ReadData, Ready, Stall);
    modport slave(input Address, WriteData, MemRead, MemWrite, output ReadData, Ready, Stall);
endinterface

// File: rtl/wait_state_data_memory.sv
// wait_state_data_memory: data memory answering load/store after LATENCY cycles with a Ready pulse
module wait_state_data_memory #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int LATENCY = 2
) (
    input logic CLK,
    input logic RST,
    wait_state_data_memory_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] wdata_q, wdata_d, rdata_q;
    logic wr_q, wr_d, req, commit;
    logic [WIDTH-1:0] mem [DEPTH];
    assign req = bus.MemRead | bus.MemWrite;
    assign commit = state_d == RESP && state_q != RESP;
    assign bus.Ready = state_q == RESP;
    assign bus.ReadData = rdata_q;
    assign bus.Stall = req & ~bus.Ready;
    // _d holds the access being committed, so LATENCY=1 commits straight from the bus
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        idx_d = idx_q;
        wdata_d = wdata_q;
        wr_d = wr_q;
        if (state_q == IDLE && req) begin
            idx_d = bus.Address[AW+1:2];
            wdata_d = bus.WriteData;
            wr_d = bus.MemWrite;
            cnt_d = 4'(LATENCY - 1);
            state_d = LATENCY == 1 ? RESP : WAIT;
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q - 4'd1;
            state_d = cnt_q == 4'd1 ? RESP : WAIT;
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q <= '0;
            idx_q <= '0;
            wdata_q <= '0;
            wr_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            wdata_q <= wdata_d;
            wr_q <= wr_d;
            if (commit) rdata_q <= mem[idx_d];
        end
    end
    always_ff @(posedge CLK) begin
        if (commit && wr_d && !RST) mem[idx_d] <= wdata_d;
    end
endmodule

// File: tb/tb_wait_state_data_memory.sv
// tb_wait_state_data_memory: directed table checks on LATENCY=2, 1 and 4 instances sharing one stimulus
module tb_wait_state_data_memory;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic rd;
        logic wr;
        logic keep;
        int lat;
        int stall;
        logic chk;
        logic [31:0] data;
    } txn_t;
    logic CLK = 1'b0;
    logic RST;
    logic [31:0] Address, WriteData;
    logic MemRead, MemWrite;
    logic [2:0] rdy, stl;
    logic [31:0] rdat [3];
    int sel = 0;
    int n_chk = 0;
    int n_fail = 0;
    always #5 CLK = ~CLK;
    for (genvar i = 0; i < 3; i++) begin : u
        wait_state_data_memory_if #(.WIDTH(32)) bus ();
        assign bus.Address = Address;
        assign bus.WriteData = WriteData;
        assign bus.MemRead = MemRead;
        assign bus.MemWrite = MemWrite;
        assign rdy[i] = bus.Ready;
        assign stl[i] = bus.Stall;
        assign rdat[i] = bus.ReadData;
        wait_state_data_memory #(.WIDTH(32), .DEPTH(64), .LATENCY(i == 0 ? 2 : i == 1 ? 1 : 4)) dut (
            .CLK(CLK),
            .RST(RST),
            .bus(bus)
        );
    end
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (dut %0d): got %h, expected %h", name, sel, act, exp);
        end
    endtask
    task automatic access(input txn_t t);
        int n, st;
        MemRead = t.rd;
        MemWrite = t.wr;
        Address = t.addr;
        WriteData = t.wdata;
        n = 0;
        st = 0;
        #1;
        do begin
            if (stl[sel]) st++;
            @(negedge CLK);
            #1;
            n++;
        end while (!rdy[sel] && n < 20);
        check("latency", n, t.lat);
        check("stall_cycles", st, t.stall);
        if (t.chk) check("read_data", rdat[sel], t.data);
        if (!t.keep) begin
            MemRead = 1'b0;
            MemWrite = 1'b0;
            @(negedge CLK);
            #1;
            check("ready_pulse", {31'b0, rdy[sel]}, 32'd0);
        end
    endtask
    task automatic pulse_reset();
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
    endtask
    txn_t tab [14];
    initial begin
        bit bad;
        txn_t t;
        tab[0]  = '{32'h10,  32'hDEADBEEF, 0, 1, 0, 2, 2, 0, 0};
        tab[1]  = '{32'h10,  0,            1, 0, 0, 2, 2, 1, 32'hDEADBEEF};
        tab[2]  = '{32'h04,  32'h11111111, 0, 1, 0, 2, 2, 0, 0};
        tab[3]  = '{32'h08,  32'h22222222, 0, 1, 0, 2, 2, 0, 0};
        tab[4]  = '{32'h04,  0,            1, 0, 1, 2, 2, 1, 32'h11111111};
        tab[5]  = '{32'h08,  0,            1, 0, 0, 3, 2, 1, 32'h22222222};
        tab[6]  = '{32'h20,  32'h1,        0, 1, 0, 2, 2, 0, 0};
        tab[7]  = '{32'h20,  32'h2,        1, 1, 0, 2, 2, 1, 32'h1};
        tab[8]  = '{32'h20,  0,            1, 0, 0, 2, 2, 1, 32'h2};
        tab[9]  = '{32'h104, 32'hA1,       0, 1, 0, 2, 2, 0, 0};
        tab[10] = '{32'h004, 0,            1, 0, 0, 2, 2, 1, 32'hA1};
        tab[11] = '{32'h13,  32'hB4,       0, 1, 0, 2, 2, 0, 0};
        tab[12] = '{32'h10,  0,            1, 0, 0, 2, 2, 1, 32'hB4};
        tab[13] = '{32'h30,  32'h77,       0, 1, 0, 2, 2, 0, 0};
        RST = 1'b1;
        MemRead = 1'b1;
        MemWrite = 1'b0;
        Address = 0;
        WriteData = 0;
        @(negedge CLK);
        @(negedge CLK);
        check("reset_ready", {31'b0, rdy[0]}, 32'd0);
        check("reset_rdata", rdat[0], 32'd0);
        check("reset_stall_req", {31'b0, stl[0]}, 32'd1);
        MemRead = 1'b0;
        #1;
        check("reset_stall_idle", {31'b0, stl[0]}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        for (int i = 0; i < 14; i++) access(tab[i]);
        // store interrupted by reset in WAIT must leave the old word in place
        MemWrite = 1'b1;
        Address = 32'h30;
        WriteData = 32'h55;
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("rst_mid_ready", {31'b0, rdy[0]}, 32'd0);
        check("rst_mid_rdata", rdat[0], 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        MemWrite = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (rdy[0]) bad = 1;
        end
        check("rst_no_ready", {31'b0, bad}, 32'd0);
        access('{32'h30, 0, 1, 0, 0, 2, 2, 1, 32'h77});
        sel = 1;
        pulse_reset();
        for (int i = 0; i < 4; i++) access('{32'h40 + 4 * i, 32'h01010101 * (i + 1), 0, 1, 0, 1, 1, 0, 0});
        for (int i = 0; i < 4; i++) access('{32'h40 + 4 * i, 0, 1, 0, 0, 1, 1, 1, 32'h01010101 * (i + 1)});
        access('{32'h40, 0, 1, 0, 1, 1, 1, 1, 32'h01010101});
        access('{32'h44, 0, 1, 0, 0, 2, 1, 1, 32'h02020202});
        sel = 2;
        pulse_reset();
        access('{32'h18, 32'hCAFE, 0, 1, 0, 4, 4, 0, 0});
        access('{32'h1C, 32'hF00D, 0, 1, 0, 4, 4, 0, 0});
        // load abandoned after one cycle still completes with the latched address
        MemRead = 1'b1;
        Address = 32'h18;
        @(negedge CLK);
        MemRead = 1'b0;
        Address = 32'h1C;
        begin
            int n;
            n = 1;
            while (!rdy[2] && n < 20) begin
                @(negedge CLK);
                n++;
            end
            check("drop_latency", n, 4);
            check("drop_rdata", rdat[2], 32'hCAFE);
        end
        @(negedge CLK);
        check("drop_ready_pulse", {31'b0, rdy[2]}, 32'd0);
        check("drop_rdata_hold", rdat[2], 32'hCAFE);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
